// File: rtl/i2s_apb_streamer_pkg.sv
// Shared types and default addresses for the I2S APB streamer.
package i2s_apb_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_st_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CTRL,
      GNT_RX,
      GNT_TX
   } gnt_t;

   localparam logic [31:0] DEF_CTRL_TX_ADDR = 32'h0000_0000;
   localparam logic [31:0] DEF_TX_ADDR      = 32'h0000_0004;
   localparam logic [31:0] DEF_RX_ADDR      = 32'h0000_0018;
   localparam logic [31:0] CTRL_INST_STRIDE = 32'h0000_0010;
   localparam int unsigned DEF_TIMEOUT      = 16;

endpackage

// File: rtl/i2s_apb_streamer_arb.sv
// Grant logic: control writes first, then round-robin between the RX poll and the TX stream.
module i2s_apb_streamer_arb
   import i2s_apb_streamer_pkg::*;
(
   input  logic pclk,
   input  logic preset,
   input  logic i_idle,
   input  logic i_ctrl_req,
   input  logic i_rx_req,
   input  logic i_tx_req,
   output gnt_t o_gnt
);

   logic r_ptr_tx;

   always_comb begin
      o_gnt = GNT_NONE;
      if (i_idle) begin
         if (i_ctrl_req) begin
            o_gnt = GNT_CTRL;
         end else if (i_rx_req && i_tx_req) begin
            o_gnt = r_ptr_tx ? GNT_TX : GNT_RX;
         end else if (i_rx_req) begin
            o_gnt = GNT_RX;
         end else if (i_tx_req) begin
            o_gnt = GNT_TX;
         end
      end
   end

   // Control grants leave the pointer alone so a control burst cannot skew RX/TX fairness.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_ptr_tx <= 1'b0;
      end else if (o_gnt == GNT_RX) begin
         r_ptr_tx <= 1'b1;
      end else if (o_gnt == GNT_TX) begin
         r_ptr_tx <= 1'b0;
      end
   end

endmodule

// File: rtl/i2s_apb_streamer.sv
// APB master upstream of I2S_top: TX stream -> TxFIFO writes, RxFIFO polls -> RX stream, control writes.
// state  | meaning
// IDLE   | grant cycle; s_tready can assert here only
// SETUP  | psel=1 penable=0; timeout counter loaded
// ACCESS | psel=1 penable=1; wait for pready or timeout
module i2s_apb_streamer
   import i2s_apb_streamer_pkg::*;
#(
   parameter logic [31:0] CTRL_TX_ADDR = DEF_CTRL_TX_ADDR,
   parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
   parameter logic [31:0] RX_ADDR      = DEF_RX_ADDR,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   input  logic        ctrl_req,
   input  logic [31:0] ctrl_addr,
   input  logic [31:0] ctrl_wdata,
   output logic        ctrl_ack,
   input  logic        tx_full,
   input  logic        rx_empty,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   output logic        err,
   output logic [15:0] tx_words,
   output logic [15:0] rx_words
);

   localparam int unsigned     TMO_W    = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
   localparam logic [31:0]     CTRL_RX_ADDR = CTRL_TX_ADDR + CTRL_INST_STRIDE;

   apb_st_t          r_state;
   gnt_t             r_kind;
   logic [TMO_W-1:0] r_tmo;
   logic             r_psel;
   logic             r_penable;
   logic             r_pwrite;
   logic [31:0]      r_paddr;
   logic [31:0]      r_pwdata;
   logic [31:0]      r_m_tdata;
   logic             r_m_tvalid;
   logic             r_ctrl_ack;
   logic             r_err;
   logic [15:0]      r_tx_words;
   logic [15:0]      r_rx_words;

   gnt_t             w_gnt;
   logic             w_ctrl_req;
   logic             w_rx_req;
   logic             w_tx_req;
   logic [31:0]      w_ctrl_paddr;

   // ctrl_req is still high during the ack cycle; masking it avoids a duplicate write.
   assign w_ctrl_req = ctrl_req & ~r_ctrl_ack;
   assign w_rx_req   = ~rx_empty & ~r_m_tvalid;
   assign w_tx_req   = s_tvalid & ~tx_full;

   // Only the two control registers are reachable; anything else lands on the TX instance.
   assign w_ctrl_paddr = (ctrl_addr == CTRL_RX_ADDR) ? CTRL_RX_ADDR : CTRL_TX_ADDR;

   i2s_apb_streamer_arb u_arb (
      .pclk       (pclk),
      .preset     (preset),
      .i_idle     (r_state == IDLE),
      .i_ctrl_req (w_ctrl_req),
      .i_rx_req   (w_rx_req),
      .i_tx_req   (w_tx_req),
      .o_gnt      (w_gnt)
   );

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_state    <= IDLE;
         r_kind     <= GNT_NONE;
         r_tmo      <= '0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
         r_ctrl_ack <= 1'b0;
         r_err      <= 1'b0;
         r_tx_words <= '0;
         r_rx_words <= '0;
      end else begin
         r_ctrl_ack <= 1'b0;
         if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_gnt != GNT_NONE) begin
                  r_state <= SETUP;
                  r_kind  <= w_gnt;
                  r_psel  <= 1'b1;
                  case (w_gnt)
                     GNT_CTRL: begin
                        r_paddr  <= w_ctrl_paddr;
                        r_pwrite <= 1'b1;
                        r_pwdata <= ctrl_wdata;
                     end
                     GNT_RX: begin
                        r_paddr  <= RX_ADDR;
                        r_pwrite <= 1'b0;
                        r_pwdata <= '0;
                     end
                     GNT_TX: begin
                        r_paddr  <= TX_ADDR;
                        r_pwrite <= 1'b1;
                        r_pwdata <= s_tdata;
                     end
                     default: ;
                  endcase
               end
            end
            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
               r_tmo     <= TMO_LOAD;
            end
            ACCESS: begin
               if (pready) begin
                  r_state   <= IDLE;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  case (r_kind)
                     GNT_CTRL: r_ctrl_ack <= 1'b1;
                     GNT_RX: begin
                        r_m_tdata  <= prdata;
                        r_m_tvalid <= 1'b1;
                        r_rx_words <= r_rx_words + 16'd1;
                     end
                     GNT_TX:   r_tx_words <= r_tx_words + 16'd1;
                     default: ;
                  endcase
               end else if (r_tmo == '0) begin
                  // Abort: the word is dropped, only the control requester is told.
                  r_state   <= IDLE;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_err     <= 1'b1;
                  if (r_kind == GNT_CTRL) begin
                     r_ctrl_ack <= 1'b1;
                  end
               end else begin
                  r_tmo <= r_tmo - TMO_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_tready = preset & (w_gnt == GNT_TX);
   assign m_tdata  = r_m_tdata;
   assign m_tvalid = r_m_tvalid;
   assign ctrl_ack = r_ctrl_ack;
   assign psel     = r_psel;
   assign penable  = r_penable;
   assign pwrite   = r_pwrite;
   assign paddr    = r_paddr;
   assign pwdata   = r_pwdata;
   assign err      = r_err;
   assign tx_words = r_tx_words;
   assign rx_words = r_rx_words;

endmodule

// File: tb/tb_i2s_apb_streamer.sv
// Directed/randomized bench for i2s_apb_streamer with a transaction-level bus scoreboard.
module tb_i2s_apb_streamer;

   localparam int K_RX   = 0;
   localparam int K_TX   = 1;
   localparam int K_CTRL = 2;

   logic        pclk = 1'b0;
   logic        preset = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        ctrl_req = 1'b0;
   logic [31:0] ctrl_addr = '0;
   logic [31:0] ctrl_wdata = '0;
   logic        ctrl_ack;
   logic        tx_full = 1'b0;
   logic        rx_empty = 1'b1;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata = '0;
   logic        pready = 1'b1;
   logic        err;
   logic [15:0] tx_words, rx_words;

   i2s_apb_streamer dut (
      .pclk(pclk), .preset(preset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .ctrl_req(ctrl_req), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_ack(ctrl_ack),
      .tx_full(tx_full), .rx_empty(rx_empty),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready),
      .err(err), .tx_words(tx_words), .rx_words(rx_words)
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model state: expected APB writes in order, read data owed to the sink.
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t         exp_wr[$];
   logic [31:0] exp_rx[$];
   int          kinds[$];
   int          n_rd_done = 0;
   int          tx_model = 0;
   logic [31:0] tx_q[$];
   bit          tx_take = 1'b0;
   logic [31:0] su_addr = '0, su_data = '0;
   logic        su_wr = 1'b0;
   wr_t         mon_w;

   // TX source: word stays offered until the DUT takes it.
   always @(negedge pclk) tx_take = s_tvalid && s_tready;
   always @(posedge pclk) begin
      #1;
      if (tx_take) begin
         void'(tx_q.pop_front());
         tx_take = 1'b0;
      end
      s_tvalid = (tx_q.size() != 0);
      s_tdata  = s_tvalid ? tx_q[0] : 32'h0;
      prdata   = $urandom;
   end

   // Bus monitor: address phase stability and completed-transfer scoreboard.
   always @(negedge pclk) begin
      if (preset && psel) begin
         if (!penable) begin
            su_addr = paddr;
            su_data = pwdata;
            su_wr   = pwrite;
         end else begin
            chk("paddr_hold", paddr, su_addr);
            chk("pwdata_hold", pwdata, su_data);
            chk("pwrite_hold", 32'(pwrite), 32'(su_wr));
            if (pready) begin
               if (pwrite) begin
                  kinds.push_back((paddr == 32'h04) ? K_TX : K_CTRL);
                  if (exp_wr.size() == 0) begin
                     chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
                  end else begin
                     mon_w = exp_wr.pop_front();
                     chk("wr_addr", paddr, mon_w.a);
                     chk("wr_data", pwdata, mon_w.d);
                  end
               end else begin
                  kinds.push_back(K_RX);
                  chk("rd_addr", paddr, 32'h18);
                  exp_rx.push_back(prdata);
                  n_rd_done++;
               end
            end
         end
      end
   end

   // RX sink.
   always @(negedge pclk) begin
      if (preset && m_tvalid && m_tready) begin
         if (exp_rx.size() == 0) chk("rx_unexpected", 32'(exp_rx.size()), 32'd1);
         else chk("rx_data", m_tdata, exp_rx.pop_front());
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic set_pready(input logic v);
      @(posedge pclk);
      #1 pready = v;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_psel"}, 32'(psel), 0);
      chk({tag, "_penable"}, 32'(penable), 0);
      chk({tag, "_pwrite"}, 32'(pwrite), 0);
      chk({tag, "_paddr"}, paddr, 0);
      chk({tag, "_pwdata"}, pwdata, 0);
      chk({tag, "_s_tready"}, 32'(s_tready), 0);
      chk({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
      chk({tag, "_m_tdata"}, m_tdata, 0);
      chk({tag, "_ctrl_ack"}, 32'(ctrl_ack), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_tx_words"}, 32'(tx_words), 0);
      chk({tag, "_rx_words"}, 32'(rx_words), 0);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] cw;
      int          got;
      int          acc;

      // Power-on reset
      run(3);
      check_reset("por");
      @(posedge pclk);
      #1 preset = 1'b1;
      run(2);

      // Reset during ACCESS: word is in flight and must vanish
      set_pready(1'b0);
      tx_q.push_back($urandom);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         if (penable) begin
            got = 1;
            break;
         end
      end
      chk("mid_access_reached", got, 1);
      #2 preset = 1'b0;
      #1 check_reset("mid_rst");
      pready = 1'b1;
      run(2);
      @(posedge pclk);
      #1 preset = 1'b1;
      run(2);

      // TX stream of four fixed words
      for (int i = 1; i <= 4; i++) begin
         w = 32'hA5A5_0000 + 32'(i);
         tx_q.push_back(w);
         exp_wr.push_back('{32'h04, w});
         tx_model++;
      end
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if (psel) begin
            got = 1;
            break;
         end
      end
      chk("tx_setup_seen", got, 1);
      chk("tx_setup_penable", 32'(penable), 0);
      chk("tx_setup_paddr", paddr, 32'h04);
      chk("tx_setup_pwdata", pwdata, 32'hA5A5_0001);
      @(negedge pclk);
      chk("tx_access_psel", 32'(psel), 1);
      chk("tx_access_penable", 32'(penable), 1);
      run(30);
      chk("tx_all_written", 32'(exp_wr.size()), 0);
      chk("tx_words_4", 32'(tx_words), 32'(tx_model));

      // Round robin with both streams pending
      kinds.delete();
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         tx_q.push_back(w);
         exp_wr.push_back('{32'h04, w});
         tx_model++;
      end
      rx_empty = 1'b0;
      run(40);
      chk("rr_count", 32'(kinds.size() >= 8), 1);
      if (kinds.size() >= 8) begin
         for (int i = 0; i < 8; i++) chk("rr_order", kinds[i], (i % 2 == 0) ? K_RX : K_TX);
      end
      tx_full = 1'b1;
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         tx_q.push_back(w);
         exp_wr.push_back('{32'h04, w});
         tx_model++;
      end
      run(2);
      kinds.delete();
      run(30);
      chk("rr_full_progress", 32'(kinds.size() >= 3), 1);
      foreach (kinds[i]) chk("rr_full_only_rx", kinds[i], K_RX);
      chk("rr_full_tx_held", 32'(tx_q.size()), 2);
      rx_empty = 1'b1;
      tx_full  = 1'b0;
      run(20);
      chk("rr_tx_drained", 32'(exp_wr.size()), 0);
      chk("rr_rx_drained", 32'(exp_rx.size()), 0);
      chk("rr_rx_words", 32'(rx_words), 32'(n_rd_done));

      // RX backpressure
      @(posedge pclk);
      #1 m_tready = 1'b0;
      run(2);
      kinds.delete();
      rx_empty = 1'b0;
      run(25);
      chk("bp_one_read", 32'(kinds.size()), 1);
      chk("bp_m_tvalid", 32'(m_tvalid), 1);
      chk("bp_pending", 32'(exp_rx.size()), 1);
      if (exp_rx.size() > 0) chk("bp_m_tdata", m_tdata, exp_rx[0]);
      run(6);
      chk("bp_still_one", 32'(kinds.size()), 1);
      if (exp_rx.size() > 0) chk("bp_m_tdata_stable", m_tdata, exp_rx[0]);
      @(posedge pclk);
      #1 m_tready = 1'b1;
      run(12);
      chk("bp_resumed", 32'(kinds.size() >= 2), 1);
      rx_empty = 1'b1;
      run(10);
      chk("bp_drained", 32'(exp_rx.size()), 0);
      chk("bp_m_tvalid_low", 32'(m_tvalid), 0);

      // Control write wins over a pending TX word
      tx_full = 1'b1;
      w = $urandom;
      tx_q.push_back(w);
      run(3);
      cw = $urandom;
      exp_wr.push_back('{32'h10, cw});
      exp_wr.push_back('{32'h04, w});
      tx_model++;
      kinds.delete();
      @(posedge pclk);
      #1;
      ctrl_addr  = 32'h10;
      ctrl_wdata = cw;
      ctrl_req   = 1'b1;
      tx_full    = 1'b0;
      got = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge pclk);
         if (ctrl_ack) begin
            got = 1;
            break;
         end
      end
      chk("ctrl_ack_seen", got, 1);
      @(posedge pclk);
      #1 ctrl_req = 1'b0;
      @(negedge pclk);
      chk("ctrl_ack_pulse", 32'(ctrl_ack), 0);
      run(10);
      chk("ctrl_two_xfers", 32'(kinds.size()), 2);
      if (kinds.size() >= 2) begin
         chk("ctrl_first", kinds[0], K_CTRL);
         chk("ctrl_then_tx", kinds[1], K_TX);
      end
      chk("ctrl_wr_done", 32'(exp_wr.size()), 0);
      chk("ctrl_tx_words", 32'(tx_words), 32'(tx_model));

      // Timeout on a TX write
      kinds.delete();
      set_pready(1'b0);
      tx_q.push_back($urandom);
      acc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge pclk);
         if (psel && penable) acc++;
         else if (acc > 0) break;
      end
      chk("tmo_access_cycles", acc, 16);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_tx_words", 32'(tx_words), 32'(tx_model));

      // Timeout on a control write still acks
      @(posedge pclk);
      #1;
      ctrl_addr  = 32'h00;
      ctrl_wdata = $urandom;
      ctrl_req   = 1'b1;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (ctrl_ack) begin
            got = 1;
            break;
         end
      end
      chk("tmo_ctrl_ack", got, 1);
      @(posedge pclk);
      #1 ctrl_req = 1'b0;
      chk("tmo_no_completion", 32'(kinds.size()), 0);

      // Recovery after timeouts
      set_pready(1'b1);
      w = $urandom;
      tx_q.push_back(w);
      exp_wr.push_back('{32'h04, w});
      tx_model++;
      run(12);
      chk("tmo_recover_written", 32'(exp_wr.size()), 0);
      chk("tmo_recover_words", 32'(tx_words), 32'(tx_model));
      chk("tmo_err_sticky", 32'(err), 1);
      chk("final_rx_words", 32'(rx_words), 32'(n_rd_done));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
